rtype_instr_encoder: RTL and testbench

- Encodes R-type ALU operations ({alu_op, rd, rs1, rs2}) into 32-bit RV32 R-type words: the inverse of the control-unit decode.
- Buffers encoded words in a small FIFO and streams them into instruction memory through a write port at incrementing word addresses.
- Used by the boot/test loader to build programs in instruction memory that the core then decodes.

---
 rtl/rtype_instr_encoder.sv | 119 +++++++++++
 tb/tb_rtype_instr_encoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtype_instr_encoder.sv
// Encodes R-type ALU operations into RV32 instruction words and streams them
// through a small FIFO into instruction memory at incrementing word addresses.
module rtype_instr_encoder #(
  parameter int unsigned             DEPTH     = 4,
  parameter int unsigned             ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]       BASE_ADDR = '0,
  parameter int unsigned             CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        alu_op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_written
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [31:0]   fifo_mem [DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr, rd_ptr_next, count, count_next;
  logic          full, push, pop;
  logic [6:0]    func7;
  logic [31:0]   enc_word, next_head;

  assign func7    = alu_op[3] ? 7'b0100000 : 7'b0000000;
  assign enc_word = {func7, rs2, rs1, alu_op[2:0], rd, 7'b0110011};

  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == FULL_CNT);
  assign in_ready = (state == RUN) && !full;
  assign push     = in_valid && in_ready;
  assign pop      = mem_we && mem_ready;

  assign rd_ptr_next = rd_ptr + (PTR_W+1)'(pop);
  assign count_next  = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

  // The write register always mirrors the FIFO head; when the head slot is
  // being filled this very cycle the encoded word is forwarded directly.
  always_comb begin
    next_head = fifo_mem[rd_ptr_next[PTR_W-1:0]];
    if (push && (rd_ptr_next == wr_ptr))
      next_head = enc_word;
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr[PTR_W-1:0]] <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= BASE_ADDR;
      mem_wdata     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      words_written <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      rd_ptr <= rd_ptr_next;

      mem_we <= (count_next != '0);
      if (count_next != '0)
        mem_wdata <= next_head;

      if (pop) begin
        mem_addr      <= mem_addr + ADDR_W'(4);
        words_written <= words_written + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            state         <= RUN;
            busy          <= 1'b1;
            mem_addr      <= BASE_ADDR;
            words_written <= '0;
          end
        end
        RUN: begin
          if (push && in_last)
            state <= DRAIN;
        end
        DRAIN: begin
          if ((count == '0) && !mem_we) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtype_instr_encoder.sv
// Directed self-checking bench for rtype_instr_encoder; a second instance with
// a non-zero base address shares the stimulus to check address continuity.
module tb_rtype_instr_encoder;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last, mem_ready;
  logic [3:0]  alu_op;
  logic [4:0]  rd, rs1, rs2;

  logic        in_ready, mem_we, busy, done;
  logic [31:0] mem_addr, mem_wdata;
  logic [15:0] words_written;

  logic        b_in_ready, b_mem_we, b_busy, b_done;
  logic [31:0] b_mem_addr, b_mem_wdata;
  logic [15:0] b_words_written;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] wa_q[$], wd_q[$], bwa_q[$];
  int          cyc_q[$];

  rtype_instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .alu_op(alu_op), .rd(rd), .rs1(rs1), .rs2(rs2),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .words_written(words_written)
  );

  rtype_instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h100), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_last(in_last), .alu_op(alu_op), .rd(rd), .rs1(rs1), .rs2(rs2),
    .mem_we(b_mem_we), .mem_ready(mem_ready), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .busy(b_busy), .done(b_done), .words_written(b_words_written)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change just after a rising edge, so the negedge view is what
  // the next rising edge will see.
  always @(negedge clk) begin
    if (mem_we && mem_ready) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
      cyc_q.push_back(cyc);
    end
    if (b_mem_we && mem_ready)
      bwa_q.push_back(b_mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] d,
                                      input logic [4:0] s1, input logic [4:0] s2);
    logic [31:0] w;
    w = 32'h33;
    w = w | (32'(d) << 7);
    w = w | (32'(op & 4'h7) << 12);
    w = w | (32'(s1) << 15);
    w = w | (32'(s2) << 20);
    if (op[3]) w = w | 32'h4000_0000;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    bwa_q.delete();
    cyc_q.delete();
  endtask

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_op(input logic [3:0] op, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic last, output int stalls);
    alu_op = op; rd = d; rs1 = s1; rs2 = s2;
    in_valid = 1'b1;
    in_last  = last;
    stalls   = 0;
    #1;
    while (!in_ready && stalls < 100) begin
      tick();
      stalls++;
    end
    if (stalls >= 100) check("push_timeout", 32'd0, 32'd1);
    else tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  logic [3:0]  ops [8] = '{4'h0, 4'h8, 4'h1, 4'h2, 4'h3, 4'h4, 4'hD, 4'h7};
  logic [31:0] a0, d0;
  int          st, total_st, n0;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_ready = 1'b0;
    alu_op = '0; rd = '0; rs1 = '0; rs2 = '0;
    repeat (3) tick();

    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_b_mem_addr", b_mem_addr, 32'h100);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_words", 32'(words_written), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd0);

    // single add
    clear_log();
    mem_ready = 1'b1;
    start_session();
    check("add_busy", 32'(busy), 32'd1);
    push_op(4'h0, 5'd3, 5'd1, 5'd2, 1'b1, st);
    check("add_stall", 32'(st), 32'd0);
    wait_done("add");
    check("add_nwrites", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() == 1) begin
      check("add_addr", wa_q[0], 32'h0);
      check("add_data", wd_q[0], 32'h002081B3);
    end
    check("add_words", 32'(words_written), 32'd1);

    // single sub
    clear_log();
    start_session();
    check("sub_words_cleared", 32'(words_written), 32'd0);
    push_op(4'h8, 5'd5, 5'd6, 5'd7, 1'b1, st);
    wait_done("sub");
    check("sub_nwrites", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() == 1) begin
      check("sub_addr", wa_q[0], 32'h0);
      check("sub_data", wd_q[0], 32'h407302B3);
    end

    // backpressure: four fill the FIFO, fifth waits
    clear_log();
    mem_ready = 1'b0;
    start_session();
    for (int i = 0; i < 4; i++) begin
      push_op(ops[i], 5'(i + 1), 5'(i + 10), 5'(i + 20), 1'b0, st);
      check("bp_accept", 32'(st), 32'd0);
    end
    alu_op = ops[4]; rd = 5'd5; rs1 = 5'd14; rs2 = 5'd24; in_valid = 1'b1; in_last = 1'b1;
    #1;
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    check("bp_mem_we", 32'(mem_we), 32'd1);
    a0 = mem_addr;
    d0 = mem_wdata;
    check("bp_head_data", d0, enc(ops[0], 5'd1, 5'd10, 5'd20));
    check("bp_head_addr", a0, 32'h0);
    repeat (3) tick();
    check("bp_stable_addr", mem_addr, a0);
    check("bp_stable_data", mem_wdata, d0);
    check("bp_stable_we", 32'(mem_we), 32'd1);
    check("bp_still_full", 32'(in_ready), 32'd0);
    mem_ready = 1'b1;
    push_op(ops[4], 5'd5, 5'd14, 5'd24, 1'b1, st);
    wait_done("bp");
    check("bp_nwrites", 32'(wa_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < wa_q.size(); i++) begin
      check("bp_addr", wa_q[i], 32'(4 * i));
      check("bp_data", wd_q[i], enc(ops[i], 5'(i + 1), 5'(i + 10), 5'(i + 20)));
    end
    check("bp_words", 32'(words_written), 32'd5);

    // streaming: 8 continuous pushes, back-to-back writes
    clear_log();
    start_session();
    total_st = 0;
    for (int i = 0; i < 8; i++) begin
      push_op(ops[i], 5'(31 - i), 5'(i), 5'(2 * i), (i == 7), st);
      total_st += st;
    end
    wait_done("stream");
    check("stream_in_ready", 32'(total_st), 32'd0);
    check("stream_nwrites", 32'(wa_q.size()), 32'd8);
    if (cyc_q.size() == 8)
      check("stream_b2b", 32'(cyc_q[7] - cyc_q[0]), 32'd7);
    for (int i = 0; i < 8 && i < wa_q.size(); i++) begin
      check("stream_addr", wa_q[i], 32'(4 * i));
      check("stream_data", wd_q[i], enc(ops[i], 5'(31 - i), 5'(i), 5'(2 * i)));
    end
    check("stream_words", 32'(words_written), 32'd8);

    // start during RUN is ignored; base 0x100 instance continues its addresses
    clear_log();
    start_session();
    push_op(4'h0, 5'd1, 5'd2, 5'd3, 1'b0, st);
    push_op(4'h8, 5'd4, 5'd5, 5'd6, 1'b0, st);
    start_session();
    check("restart_busy", 32'(b_busy), 32'd1);
    push_op(4'h4, 5'd7, 5'd8, 5'd9, 1'b0, st);
    push_op(4'h6, 5'd10, 5'd11, 5'd12, 1'b1, st);
    wait_done("restart");
    check("restart_nwrites", 32'(bwa_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < bwa_q.size(); i++)
      check("restart_b_addr", bwa_q[i], 32'h100 + 32'(4 * i));
    check("restart_b_words", 32'(b_words_written), 32'd4);
    check("restart_words", 32'(words_written), 32'd4);

    // reset in DRAIN with 3 words buffered
    clear_log();
    mem_ready = 1'b0;
    start_session();
    push_op(4'h1, 5'd1, 5'd1, 5'd1, 1'b0, st);
    push_op(4'h2, 5'd2, 5'd2, 5'd2, 1'b0, st);
    push_op(4'h3, 5'd3, 5'd3, 5'd3, 1'b1, st);
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_in_ready", 32'(in_ready), 32'd0);
    check("drain_mem_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_words", 32'(words_written), 32'd0);
    rst = 1'b0;
    mem_ready = 1'b1;
    n0 = wa_q.size();
    repeat (6) tick();
    check("mid_rst_no_writes", 32'(wa_q.size()), 32'(n0));
    check("mid_rst_we_low", 32'(mem_we), 32'd0);
    check("mid_rst_empty", 32'(n0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
